dot4_mac_engine: RTL and testbench
==================================

# dot4_mac_engine

Compute stage directly downstream of the weight/data SPI shift-in registers. On `start` it snapshots the 32-bit weight word (4 signed 8-bit weights) and the 128-bit data word (4 vectors × 4 signed 8-bit activations). It computes four dot products with a single multiply-accumulate unit, one MAC per cycle. Results are quantised to signed 8-bit and streamed out over a valid/ready handshake toward the output pins.

## Interface
- `SHIFT`, default 2: arithmetic right shift applied to each 18-bit dot product before saturation.
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a computation; sampled only in IDLE.
- `weights` in 32: w[i] = `weights[8i+7:8i]`, i=0..3, signed.
- `data` in 128: x[j][i] = `data[32j+8i+7:32j+8i]`, j,i=0..3, signed.
- `relu_en` in 1: clamp negative results to 0; sampled with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until the final output handshake.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `out_data` out 8: quantised result y[j], signed.
- `out_idx` out 2: j of current result.
- `out_last` out 1: high with `out_idx`==3.
- `done` out 1: one-cycle pulse after the final handshake.

## Operation
- States: IDLE, MAC, OUT.
- IDLE + `start`: capture `weights`, `data`, `relu_en` into internal snapshot registers. Clear the accumulator and set counters j=0, i=0. Go to MAC.
- Later changes on `weights`/`data` have no effect until the next accepted `start`.
- MAC, each cycle: acc += w[i]·x[j][i].
  - Product: 16-bit signed. Accumulator: 18-bit signed, so no overflow is possible.
  - At i==3: store acc+product into result[j], clear acc, i←0, j←j+1.
  - After j==3,i==3: go to OUT with index 0.
- Quantisation, combinational on the stored result: q = result >>> SHIFT (arithmetic).
  - relu_en=0: saturate q to [-128,127].
  - relu_en=1: saturate q to [0,127].
- OUT:
  - `out_valid`=1, `out_data`=quant(result[idx]), `out_idx`=idx, `out_last`=(idx==3).
  - Handshake = `out_valid`&&`out_ready`. On a handshake idx increments; on the handshake with idx==3, go to IDLE and pulse `done`.
- `start` in MAC or OUT is ignored and is not queued.
- `rst` overrides all other inputs, including a simultaneous `start`.
  - Mid-operation reset aborts: no further `out_valid`, results discarded.

## Timing
- Reset values:
  - `busy`, `out_valid`, `out_last`, `done` = 0.
  - `out_data`, `out_idx` = 0.
  - State IDLE; accumulator, counters and snapshots cleared.
- Edge E0 samples `start` → `busy`=1 after E0.
- MAC occupies edges E1..E16; `out_valid`=1 after E16. Fixed latency is 16 cycles.
- With `out_ready` held high, the four results leave on consecutive cycles, E17..E20.
  - `done`=1 and `busy`=0 for the cycle after E20.
  - A new `start` can be accepted in that same cycle.
- Output hold rule: while `out_valid`&&!`out_ready`, `out_data`, `out_idx` and `out_last` stay stable. `out_valid` never drops without a handshake (except on `rst`).
- `done` is exactly one cycle wide and occurs only after a complete output sequence.

## Structure
- Shared package `dot4_mac_pkg` holds:
  - state enum (IDLE/MAC/OUT);
  - constants N_ELEM=4, ELEM_W=8, PROD_W=16, ACC_W=18.
- Sub-module `dot4_quant`: combinational shift/ReLU/saturate, 18-bit in → 8-bit out, with `SHIFT` and `relu_en`.
- Top-level content: FSM, counters, snapshot registers, the MAC datapath and the 4×18-bit result buffer.

## Test plan
- All w=1, all x=16, relu_en=0, SHIFT=2, out_ready=1 → results 16,16,16,16 on `out_idx` 0..3. `out_valid` rises 16 edges after `start`; `done` pulses once.
- w=127, all x=127 → 64516>>>2=16129 → all 127. w=-128, all x=127, relu_en=0 → all -128; same stimulus with relu_en=1 → all 0.
- Signed mix: w={1,-1,2,-2}, x[0]={8,4,4,2}, x[1..3] all 0 → y0=8>>>2=2, y1..y3=0.
- Backpressure: hold out_ready=0 for 5 cycles after `out_valid` → `out_data`/`out_idx`=0 held stable. Then toggle out_ready every other cycle → exactly 4 handshakes, `out_last` only on idx 3.
- Start while busy, plus changing `weights`/`data` mid-MAC → no restart; results match the snapshot taken at the accepted `start`.
- Assert `rst` 8 cycles into MAC → next cycle `busy`=0 and `out_valid` never asserts. A fresh `start` then produces correct results. `rst`+`start` in the same cycle → remains IDLE.

Source files
------------

// File: rtl/dot4_mac_pkg.sv
// Shared types and sizing constants for the dot4 MAC engine.
// The state enum and element/product/accumulator widths are used by the top and the quantiser.
package dot4_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int N_ELEM = 4;
    localparam int ELEM_W = 8;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 18;

endpackage

// File: rtl/dot4_quant.sv
// Combinational quantiser: arithmetic shift of an 18-bit dot product, optional ReLU,
// then saturation to a signed 8-bit result.
module dot4_quant
    import dot4_mac_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic signed [ACC_W-1:0]  result,
    input  logic                     relu_en,
    output logic signed [ELEM_W-1:0] q
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = result >>> SHIFT;

    // ReLU moves the lower clamp from -128 up to 0.
    always_comb begin
        q = shifted[ELEM_W-1:0];
        if (relu_en && shifted < 0) begin
            q = '0;
        end else if (shifted > 18'sd127) begin
            q = 8'sd127;
        end else if (shifted < -18'sd128) begin
            q = -8'sd128;
        end
    end

endmodule

// File: rtl/dot4_mac_engine.sv
// Four 4-element signed dot products on one shared MAC unit, one MAC per cycle,
// with quantised results streamed out over a valid/ready handshake.
module dot4_mac_engine
    import dot4_mac_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  weights,
    input  logic [127:0] data,
    input  logic         relu_en,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         done
);

    state_t state, next_state;

    logic [31:0]  w_snap;
    logic [127:0] x_snap;
    logic         relu_snap;
    logic [1:0]   i_cnt, j_cnt;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  result_buf [N_ELEM];
    logic signed [ELEM_W-1:0] w_sel, x_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ELEM_W-1:0] q;

    // Element offsets: w[i] at 8i, x[j][i] at 32j+8i.
    assign w_sel   = w_snap[{i_cnt, 3'b000} +: ELEM_W];
    assign x_sel   = x_snap[{j_cnt, i_cnt, 3'b000} +: ELEM_W];
    assign prod    = w_sel * x_sel;
    assign mac_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = MAC;
            MAC:  if (j_cnt == 2'd3 && i_cnt == 2'd3) next_state = OUT;
            OUT:  if (out_ready && out_idx == 2'd3) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_snap    <= '0;
            x_snap    <= '0;
            relu_snap <= 1'b0;
            acc       <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
            for (int k = 0; k < N_ELEM; k++) begin
                result_buf[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_snap    <= weights;
                        x_snap    <= data;
                        relu_snap <= relu_en;
                        acc       <= '0;
                        i_cnt     <= '0;
                        j_cnt     <= '0;
                        out_idx   <= '0;
                    end
                end
                MAC: begin
                    // Last element of a vector: retire the sum and restart the accumulator.
                    if (i_cnt == 2'd3) begin
                        result_buf[j_cnt] <= mac_sum;
                        acc               <= '0;
                        i_cnt             <= '0;
                        j_cnt             <= j_cnt + 2'd1;
                    end else begin
                        acc   <= mac_sum;
                        i_cnt <= i_cnt + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_idx <= out_idx + 2'd1;
                        if (out_idx == 2'd3) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    dot4_quant #(
        .SHIFT(SHIFT)
    ) u_quant (
        .result  (result_buf[out_idx]),
        .relu_en (relu_snap),
        .q       (q)
    );

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_last  = (state == OUT) && (out_idx == 2'd3);
    assign out_data  = q;

endmodule

// File: tb/tb_dot4_mac_engine.sv
// Directed bench for dot4_mac_engine: a table of hand-computed vectors plus
// sequences for backpressure, start-while-busy, mid-operation reset and rst+start.
module tb_dot4_mac_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  weights;
    logic [127:0] data;
    logic         relu_en;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         done;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [31:0]  w;
        logic [127:0] x;
        logic         relu;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    dot4_mac_engine #(.SHIFT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .weights   (weights),
        .data      (data),
        .relu_en   (relu_en),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        logic [7:0] ba, bb, bc, bd;
        ba = 8'(a);
        bb = 8'(b);
        bc = 8'(c);
        bd = 8'(d);
        return {bd, bc, bb, ba};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one accepted start (edge E0) and leaves the bench sampling #1 after E0.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        weights = v.w;
        data    = v.x;
        relu_en = v.relu;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Full run with out_ready high; optionally disturbs inputs and re-pulses start mid-MAC.
    task automatic run_vector(input vec_t v, input string tag, input bit disturb);
        int cycles;
        out_ready = 1'b1;
        applyStimulus(v);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (disturb && cycles == 5) begin
                weights = 32'hA5C3_7F81;
                data    = {4{32'h8001_7E3C}};
                relu_en = ~v.relu;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checkOutput({tag, "_latency"}, cycles, 32'd16);
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
            checkOutput({tag, "_idx"}, {30'b0, out_idx}, k);
            checkOutput({tag, "_data"}, {24'b0, out_data}, {24'b0, v.exp[8*k +: 8]});
            checkOutput({tag, "_last"}, {31'b0, out_last}, (k == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
        checkOutput({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_valid_end"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_width"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_no_restart"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cycles, hs, dones, vcount;

        // w = weights, x rows j=0..3, expected y0..y3 with SHIFT=2
        vecs[0] = '{pack4(1, 1, 1, 1), {4{pack4(16, 16, 16, 16)}}, 1'b0, pack4(16, 16, 16, 16)};
        vecs[1] = '{pack4(127, 127, 127, 127), {4{pack4(127, 127, 127, 127)}}, 1'b0,
                    pack4(127, 127, 127, 127)};
        vecs[2] = '{pack4(-128, -128, -128, -128), {4{pack4(127, 127, 127, 127)}}, 1'b0,
                    pack4(-128, -128, -128, -128)};
        vecs[3] = '{pack4(-128, -128, -128, -128), {4{pack4(127, 127, 127, 127)}}, 1'b1,
                    pack4(0, 0, 0, 0)};
        vecs[4] = '{pack4(1, -1, 2, -2), {96'b0, pack4(8, 4, 4, 2)}, 1'b0, pack4(2, 0, 0, 0)};
        vecs[5] = '{pack4(1, 2, 3, 4),
                    {pack4(5, 5, 5, 5), pack4(0, 0, 0, 20), pack4(-1, -1, -1, -1), pack4(1, 1, 1, 1)},
                    1'b0, pack4(2, -3, 20, 12)};
        vecs[6] = '{vecs[5].w, vecs[5].x, 1'b1, pack4(2, 0, 20, 12)};

        rst       = 1'b1;
        start     = 1'b0;
        weights   = '0;
        data      = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_data", {24'b0, out_data}, 32'd0);
        checkOutput("rst_idx", {30'b0, out_idx}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_vector(vecs[v], $sformatf("vec%0d", v), 1'b0);
        end

        // Start while busy plus input changes mid-MAC must not disturb the snapshot.
        run_vector(vecs[5], "busy_start", 1'b1);

        // Backpressure: stall 5 cycles, then toggle out_ready every other cycle.
        out_ready = 1'b0;
        applyStimulus(vecs[5]);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("bp_latency", cycles, 32'd16);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_hold_idx", {30'b0, out_idx}, 32'd0);
            checkOutput("bp_hold_data", {24'b0, out_data}, {24'b0, vecs[5].exp[7:0]});
            @(posedge clk);
            #1;
        end
        hs = 0;
        dones = 0;
        cycles = 0;
        out_ready = 1'b1;
        while (hs < 4 && cycles < 30) begin
            if (out_valid) begin
                checkOutput("bp_last", {31'b0, out_last}, (out_idx == 2'd3) ? 32'd1 : 32'd0);
            end
            if (out_valid && out_ready) begin
                checkOutput("bp_idx", {30'b0, out_idx}, hs);
                checkOutput("bp_data", {24'b0, out_data}, {24'b0, vecs[5].exp[8*hs +: 8]});
                hs++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (done) dones++;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (done) dones++;
        checkOutput("bp_handshakes", hs, 32'd4);
        checkOutput("bp_done_count", dones, 32'd1);
        checkOutput("bp_valid_end", {31'b0, out_valid}, 32'd0);

        // Reset 8 cycles into MAC aborts the operation.
        applyStimulus(vecs[0]);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) vcount++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_valid", vcount, 32'd0);
        run_vector(vecs[5], "after_abort", 1'b0);

        // rst and start together: rst wins.
        @(negedge clk);
        weights = vecs[0].w;
        data    = vecs[0].x;
        rst     = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_start_idle", {31'b0, busy}, 32'd0);
        checkOutput("rst_start_valid", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
